// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode bundle for instr_fetch_queue.
//   Carries the redirect request coming from the branch/jump logic and the
//   valid/ready instruction stream offered to decode.
//   master : the fetch queue (drives out_*, occupancy; receives out_ready
//            and the redirect request)
//   slave  : the consumer side (decode plus the redirect source)
// Signals
//   redirect_valid  load redirect_pc and flush everything queued / in flight
//   redirect_pc     target byte address
//   out_valid       queue head valid
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction (0 when empty or faulted)
//   out_pc          byte address of the head instruction
//   out_fault       head was fetched from a misaligned / out-of-range PC
//   occupancy       entries currently held in the queue
`timescale 1ns/1ps
interface instr_fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) ();
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_fault;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready,
        output out_valid,
        output out_instr,
        output out_pc,
        output out_fault,
        output occupancy
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        output out_ready,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_fault,
        input  occupancy
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry fetch queue.
//   Owns the fetch PC, reads a synchronous word-indexed instruction ROM and
//   buffers the fetched words in a circular queue that decode drains over a
//   valid/ready handshake. A redirect flushes the queue, squashes the read in
//   flight and restarts fetch at the new target.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   fq     instr_fetch_queue_if.master: redirect request in, instruction
//          stream (out_valid/out_ready/out_instr/out_pc/out_fault) and
//          occupancy out
`timescale 1ns/1ps
module instr_fetch_queue #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                MEM_IDX_W = 10,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter                    INIT_FILE = "rom.hex"
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_queue_if.master fq
);
    localparam int OCC_W     = $clog2(DEPTH + 1);
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROM_WORDS = 1 << MEM_IDX_W;

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t             LAST_PTR      = ptr_t'(DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_CREDITS = (OCC_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Instruction ROM (block RAM, registered read)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rom [0:ROM_WORDS-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              inflight_reg, inflight_next;
    logic [ADDR_W-1:0] infl_pc_reg, infl_pc_next;
    logic              infl_fault_reg, infl_fault_next;
    logic [DATA_W-1:0] rom_data_reg;
    ptr_t              head_reg, head_next;
    ptr_t              tail_reg, tail_next;
    logic [OCC_W-1:0]  count_reg, count_next;

    logic [DATA_W-1:0] q_instr [0:DEPTH-1];
    logic [ADDR_W-1:0] q_pc    [0:DEPTH-1];
    logic              q_fault [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic                 pc_out_of_range;
    logic                 pc_fault;
    logic [MEM_IDX_W-1:0] rom_idx;
    logic [OCC_W:0]       credits_used;
    logic                 issue_en;
    logic                 push_en;
    logic                 pop_en;
    logic                 head_valid;
    logic [DATA_W-1:0]    push_instr;

    generate
        if (MEM_IDX_W + 2 < ADDR_W) begin : g_range_chk
            assign pc_out_of_range = |pc_reg[ADDR_W-1:MEM_IDX_W+2];
        end else begin : g_no_range_chk
            assign pc_out_of_range = 1'b0;
        end
    endgenerate

    assign pc_fault = (pc_reg[1:0] != 2'b00) || pc_out_of_range;
    assign rom_idx  = pc_reg[MEM_IDX_W+1:2];

    // A read is issued only if the queue can absorb it even without the
    // pop happening at this edge; this keeps the full check off the
    // out_ready path and makes overflow impossible.
    assign credits_used = {1'b0, count_reg} + {{OCC_W{1'b0}}, inflight_reg};
    assign issue_en     = !fq.redirect_valid && (credits_used < DEPTH_CREDITS);

    // Redirect squashes the in-flight word and ignores any pop.
    assign push_en    = inflight_reg && !fq.redirect_valid;
    assign head_valid = (count_reg != '0);
    assign pop_en     = head_valid && fq.out_ready && !fq.redirect_valid;

    // Faulted fetches enter the queue as a nop.
    assign push_instr = infl_fault_reg ? '0 : rom_data_reg;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        pc_next         = pc_reg;
        inflight_next   = 1'b0;
        infl_pc_next    = infl_pc_reg;
        infl_fault_next = infl_fault_reg;
        head_next       = head_reg;
        tail_next       = tail_reg;
        count_next      = count_reg;

        if (fq.redirect_valid) begin
            pc_next    = fq.redirect_pc;
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (issue_en) begin
                inflight_next   = 1'b1;
                infl_pc_next    = pc_reg;
                infl_fault_next = pc_fault;
                pc_next         = pc_reg + ADDR_W'(4);
            end
            if (push_en) begin
                tail_next = ptr_inc(tail_reg);
            end
            if (pop_en) begin
                head_next = ptr_inc(head_reg);
            end
            if (push_en && !pop_en) begin
                count_next = count_reg + OCC_W'(1);
            end else if (pop_en && !push_en) begin
                count_next = count_reg - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg         <= RESET_PC;
            inflight_reg   <= 1'b0;
            infl_pc_reg    <= '0;
            infl_fault_reg <= 1'b0;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
        end else begin
            pc_reg         <= pc_next;
            inflight_reg   <= inflight_next;
            infl_pc_reg    <= infl_pc_next;
            infl_fault_reg <= infl_fault_next;
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            count_reg      <= count_next;
        end
    end

    // ROM read port: data lands one edge after issue, alongside inflight_reg.
    always_ff @(posedge clk) begin
        if (issue_en) begin
            rom_data_reg <= rom[rom_idx];
        end
    end

    // Queue storage carries no reset; validity is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (push_en) begin
            q_instr[tail_reg] <= push_instr;
            q_pc[tail_reg]    <= infl_pc_reg;
            q_fault[tail_reg] <= infl_fault_reg;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head entry, forced to zero when the queue is empty
    // ------------------------------------------------------------------
    assign fq.out_valid = head_valid;
    assign fq.out_instr = head_valid ? q_instr[head_reg] : '0;
    assign fq.out_pc    = head_valid ? q_pc[head_reg]    : '0;
    assign fq.out_fault = head_valid ? q_fault[head_reg] : 1'b0;
    assign fq.occupancy = count_reg;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue (DEPTH=4, MEM_IDX_W=10).
//   ROM is preloaded with ROM[i] = i*0x11. A queue-based reference model
//   tracks which fetched words must be visible; every falling edge the DUT
//   head/occupancy is compared with it, and directed scenarios add literal
//   expectations.
`timescale 1ns/1ps
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    logic clk;
    logic rst_n;

    int tests = 0;
    int fails = 0;

    instr_fetch_queue_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) fq_bus ();

    instr_fetch_queue #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .MEM_IDX_W(10),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .INIT_FILE("")
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fq   (fq_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    ent_t        mq[$];
    int          m_infl = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_infl_pc = 32'h0;

    function automatic ent_t fetch_word(input logic [31:0] pc);
        ent_t e;
        e.pc    = pc;
        e.fault = (pc % 4 != 0) || (pc >= 32'd4096);
        e.instr = e.fault ? 32'h0 : (pc / 4) * 32'h11;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_infl = 0;
        m_pc   = 32'h0;
    endtask

    // Applies one rising edge using the inputs that were set before it.
    task automatic model_edge();
        bit issue;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (fq_bus.redirect_valid) begin
            mq.delete();
            m_infl = 0;
            m_pc   = fq_bus.redirect_pc;
            return;
        end
        issue = (mq.size() + m_infl) < DEPTH;
        if (mq.size() != 0 && fq_bus.out_ready) void'(mq.pop_front());
        if (m_infl != 0) mq.push_back(fetch_word(m_infl_pc));
        if (issue) begin
            m_infl    = 1;
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
        end else begin
            m_infl = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin : cmp
        logic ev;
        ent_t h;
        ev = (mq.size() != 0);
        if (ev) h = mq[0];
        else    h = '{pc: 32'h0, instr: 32'h0, fault: 1'b0};
        tests++;
        if (fq_bus.out_valid !== ev || fq_bus.out_pc !== h.pc ||
            fq_bus.out_instr !== h.instr || fq_bus.out_fault !== h.fault ||
            32'(fq_bus.occupancy) !== 32'(mq.size())) begin
            fails++;
            $display("FAIL model_cmp t=%0t valid=%0b/%0b pc=%h/%h instr=%h/%h fault=%0b/%0b occ=%0d/%0d (got/required)",
                     $time, fq_bus.out_valid, ev, fq_bus.out_pc, h.pc,
                     fq_bus.out_instr, h.instr, fq_bus.out_fault, h.fault,
                     fq_bus.occupancy, mq.size());
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic chk_head(input string name, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr, input logic f);
        chk({name, "_valid"}, 32'(fq_bus.out_valid), 32'(v));
        chk({name, "_pc"},    fq_bus.out_pc,         pc);
        chk({name, "_instr"}, fq_bus.out_instr,      instr);
        chk({name, "_fault"}, 32'(fq_bus.out_fault), 32'(f));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Reset asserted between edges, held across two edges, released at a
    // falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        fq_bus.redirect_valid = 1'b1;
        fq_bus.redirect_pc    = target;
        cyc();
        fq_bus.redirect_valid = 1'b0;
        fq_bus.redirect_pc    = 32'h0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [31:0] t2_exp [4];

    initial begin
        rst_n                 = 1'b0;
        fq_bus.redirect_valid = 1'b0;
        fq_bus.redirect_pc    = 32'h0;
        fq_bus.out_ready      = 1'b0;
        for (int i = 0; i < 1024; i++) dut.rom[i] = 32'(i) * 32'h11;
        t2_exp[0] = 32'h4; t2_exp[1] = 32'h8; t2_exp[2] = 32'hC; t2_exp[3] = 32'h10;

        // Reset state
        cyc();
        cyc();
        chk_head("reset", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("reset_occ", 32'(fq_bus.occupancy), 32'd0);

        // T1: streaming from RESET_PC
        rst_n            = 1'b1;
        fq_bus.out_ready = 1'b1;
        cyc();
        chk("t1_after_issue_valid", 32'(fq_bus.out_valid), 32'd0);
        cyc();
        chk_head("t1_w0", 1'b1, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_head("t1_w1", 1'b1, 32'h4, 32'h11, 1'b0);
        cyc();
        chk_head("t1_w2", 1'b1, 32'h8, 32'h22, 1'b0);
        chk("t1_occ", 32'(fq_bus.occupancy), 32'd1);
        repeat (3) cyc();

        // T2: decode stalled, queue saturates without overflow
        fq_bus.out_ready = 1'b0;
        do_reset();
        repeat (10) cyc();
        chk("t2_occ_full", 32'(fq_bus.occupancy), 32'd4);
        chk_head("t2_head", 1'b1, 32'h0, 32'h0, 1'b0);
        fq_bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("t2_drain%0d_pc", k), fq_bus.out_pc, t2_exp[k]);
        end

        // T3 / T5a: redirect while 3 queued + 1 in flight, head offered
        fq_bus.out_ready = 1'b0;
        do_reset();
        repeat (4) cyc();
        chk("t3_occ_before", 32'(fq_bus.occupancy), 32'd3);
        fq_bus.out_ready = 1'b1;
        redirect(32'h40);
        chk("t3_occ_after_R", 32'(fq_bus.occupancy), 32'd0);
        chk("t3_valid_after_R", 32'(fq_bus.out_valid), 32'd0);
        cyc();
        chk("t3_valid_after_R1", 32'(fq_bus.out_valid), 32'd0);
        cyc();
        chk_head("t3_target", 1'b1, 32'h40, 32'h110, 1'b0);

        // T4: faulting fetches
        redirect(32'h42);
        cyc();
        cyc();
        chk_head("t4_mis0", 1'b1, 32'h42, 32'h0, 1'b1);
        cyc();
        chk_head("t4_mis1", 1'b1, 32'h46, 32'h0, 1'b1);
        redirect(32'hFFC);
        cyc();
        cyc();
        chk_head("t4_last_word", 1'b1, 32'hFFC, 32'h43EF, 1'b0);
        cyc();
        chk_head("t4_past_end", 1'b1, 32'h1000, 32'h0, 1'b1);
        redirect(32'h1000);
        cyc();
        cyc();
        chk_head("t4_oob", 1'b1, 32'h1000, 32'h0, 1'b1);

        // T5b: back-to-back redirects, the second wins
        fq_bus.redirect_valid = 1'b1;
        fq_bus.redirect_pc    = 32'h80;
        cyc();
        fq_bus.redirect_pc    = 32'h100;
        cyc();
        fq_bus.redirect_valid = 1'b0;
        fq_bus.redirect_pc    = 32'h0;
        chk("t5_valid_after_R2", 32'(fq_bus.out_valid), 32'd0);
        cyc();
        cyc();
        chk_head("t5_second_target", 1'b1, 32'h100, 32'h440, 1'b0);

        // T6: asynchronous reset mid-stream, then PC wrap
        cyc();
        chk("t6_pre_valid", 32'(fq_bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_head("t6_async", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t6_async_occ", 32'(fq_bus.occupancy), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk_head("t6_restart0", 1'b1, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_head("t6_restart1", 1'b1, 32'h4, 32'h11, 1'b0);
        redirect(32'hFFFF_FFFC);
        cyc();
        cyc();
        chk_head("t6_top", 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1);
        cyc();
        chk_head("t6_wrap", 1'b1, 32'h0, 32'h0, 1'b0);
        cyc();
        chk_head("t6_wrap_next", 1'b1, 32'h4, 32'h11, 1'b0);

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
